// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and defaults for the Infinity Tower game-flow logic.
//   screen_t : screen / game-phase selector consumed by the renderer and HUD
//   *_DEF    : default values for the game_ctrl parameters
//   *_W      : HUD counter widths
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    SCR_START   = 3'd0,
    SCR_PLAY    = 3'd1,
    SCR_PAUSE   = 3'd2,
    SCR_RESPAWN = 3'd3,
    SCR_OVER    = 3'd4,
    SCR_WIN     = 3'd5
  } screen_t;

  localparam int LIVES_INIT_DEF     = 3;
  localparam int LEVEL_MAX_DEF      = 4;
  localparam int FRAMES_PER_SEC_DEF = 60;
  localparam int RESPAWN_FRAMES_DEF = 90;
  localparam int TIME_MAX_DEF       = 999;

  localparam int SCREEN_W = 3;
  localparam int LEVEL_W  = 3;
  localparam int LIVES_W  = 2;
  localparam int TIME_W   = 10;

endpackage

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// One-register rising-edge detector. The pulse lasts exactly one clk.
//   clk   : clock
//   rst   : synchronous active-high reset
//   in    : level input
//   pulse : high for one clk when 'in' rises
// The armed flag suppresses the pulse in the first clk after reset, so a
// level that was already high during reset is not reported as an edge.
// -----------------------------------------------------------------------------
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= in;
      armed_q <= 1'b1;
    end
  end

  assign pulse = in & ~prev_q & armed_q;

endmodule

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Game-flow controller: START / PLAY / PAUSE / RESPAWN / OVER / WIN.
//   clk, rst     : clock, synchronous active-high reset
//   vsync        : VGA vsync, rising edge = one frame tick
//   key_enter    : enter key level (start game / abandon / restart)
//   key_space    : space key level (pause toggle)
//   hit_hazard   : player touches hazard (level)
//   at_exit      : player at exit door (level, acted on per rising edge)
//   screen       : screen_t selector for the renderer
//   game_run     : movement enable, high only in PLAY
//   player_rst   : one-clk pulse returning the player to spawn
//   level, lives : HUD counters
//   time_sec     : elapsed play seconds, saturating at TIME_MAX
// All outputs are registers; a state change appears one clk after the
// input cycle that caused it.
// -----------------------------------------------------------------------------
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = LIVES_INIT_DEF,
  parameter int LEVEL_MAX      = LEVEL_MAX_DEF,
  parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int TIME_MAX       = TIME_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync,
  input  logic                key_enter,
  input  logic                key_space,
  input  logic                hit_hazard,
  input  logic                at_exit,
  output logic [SCREEN_W-1:0] screen,
  output logic                game_run,
  output logic                player_rst,
  output logic [LEVEL_W-1:0]  level,
  output logic [LIVES_W-1:0]  lives,
  output logic [TIME_W-1:0]   time_sec
);

  localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int RESP_W  = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [RESP_W-1:0]  RESP_LAST  = RESP_W'(RESPAWN_FRAMES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVEL_MAX);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [TIME_W-1:0]  TIME_SAT   = TIME_W'(TIME_MAX);

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic enter_p;
  logic space_p;
  logic frame_tick;
  logic exit_edge;

  edge_det u_edge_enter (.clk(clk), .rst(rst), .in(key_enter), .pulse(enter_p));
  edge_det u_edge_space (.clk(clk), .rst(rst), .in(key_space), .pulse(space_p));
  edge_det u_edge_vsync (.clk(clk), .rst(rst), .in(vsync),     .pulse(frame_tick));
  edge_det u_edge_exit  (.clk(clk), .rst(rst), .in(at_exit),   .pulse(exit_edge));

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  screen_t              state_q,      state_d;
  logic [LEVEL_W-1:0]   level_q,      level_d;
  logic [LIVES_W-1:0]   lives_q,      lives_d;
  logic [TIME_W-1:0]    time_q,       time_d;
  logic [FRAME_W-1:0]   frame_q,      frame_d;
  logic [RESP_W-1:0]    resp_q,       resp_d;
  logic                 game_run_q,   game_run_d;
  logic                 player_rst_q, player_rst_d;

  // Exit only counts while actually playing; a door touched in another phase
  // and still held on return to PLAY does not advance the level.
  logic exit_play;
  assign exit_play = exit_edge & (state_q == SCR_PLAY);

  // Time base value after one frame tick; shared by PLAY and RESPAWN.
  logic [FRAME_W-1:0] frame_adv;
  logic [TIME_W-1:0]  time_adv;

  always_comb begin
    frame_adv = frame_q + FRAME_W'(1);
    time_adv  = time_q;
    if (frame_q >= FRAME_LAST) begin
      frame_adv = '0;
      if (time_q < TIME_SAT) begin
        time_adv = time_q + TIME_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    time_d       = time_q;
    frame_d      = frame_q;
    resp_d       = resp_q;
    player_rst_d = 1'b0;

    case (state_q)
      SCR_START: begin
        if (enter_p) begin
          state_d      = SCR_PLAY;
          level_d      = '0;
          lives_d      = LIVES_LOAD;
          time_d       = '0;
          frame_d      = '0;
          player_rst_d = 1'b1;
        end
      end

      SCR_PLAY: begin
        // A tick in the same clk as a transition still belongs to PLAY.
        if (frame_tick) begin
          frame_d = frame_adv;
          time_d  = time_adv;
        end
        if (hit_hazard) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = SCR_OVER;
          end else begin
            lives_d      = lives_q - LIVES_W'(1);
            state_d      = SCR_RESPAWN;
            resp_d       = '0;
            player_rst_d = 1'b1;
          end
        end else if (exit_play) begin
          if (level_q >= LEVEL_LAST) begin
            state_d = SCR_WIN;
          end else begin
            level_d      = level_q + LEVEL_W'(1);
            player_rst_d = 1'b1;
          end
        end else if (space_p) begin
          state_d = SCR_PAUSE;
        end
      end

      SCR_PAUSE: begin
        if (space_p) begin
          state_d = SCR_PLAY;
        end else if (enter_p) begin
          state_d = SCR_START;
        end
      end

      SCR_RESPAWN: begin
        if (frame_tick) begin
          frame_d = frame_adv;
          time_d  = time_adv;
          if (resp_q >= RESP_LAST) begin
            state_d = SCR_PLAY;
          end else begin
            resp_d = resp_q + RESP_W'(1);
          end
        end
      end

      SCR_OVER, SCR_WIN: begin
        if (enter_p) begin
          state_d = SCR_START;
        end
      end

      default: begin
        state_d = SCR_START;
      end
    endcase

    game_run_d = (state_d == SCR_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCR_START;
      level_q      <= '0;
      lives_q      <= LIVES_LOAD;
      time_q       <= '0;
      frame_q      <= '0;
      resp_q       <= '0;
      game_run_q   <= 1'b0;
      player_rst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      time_q       <= time_d;
      frame_q      <= frame_d;
      resp_q       <= resp_d;
      game_run_q   <= game_run_d;
      player_rst_q <= player_rst_d;
    end
  end

  assign screen     = state_q;
  assign game_run   = game_run_q;
  assign player_rst = player_rst_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign time_sec   = time_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Central game-flow controller for the Infinity Tower design. It sequences the start, play, pause, respawn, game-over and win phases.
- Consumes keyboard levels (enter/space), player collision flags and the VGA vsync.
- Drives the screen selector for the screen renderer, the run-enable and reset pulse for the player movement FSM, and the level/lives/time counters for the HUD.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3)
- LEVEL_MAX, 4, last level index; finishing it wins (1..7)
- FRAMES_PER_SEC, 60, frame ticks per elapsed-time second
- RESPAWN_FRAMES, 90, frames spent in RESPAWN before play resumes
- TIME_MAX, 999, saturation value of time_sec

Ports:
- clk  in  1  system pixel clock (65 MHz domain)
- rst  in  1  synchronous, active-high reset
- vsync  in  1  VGA vsync from timing chain (active high)
- key_enter  in  1  enter key held (level)
- key_space  in  1  space key held (level)
- hit_hazard  in  1  player overlaps hazard (level, sampled per clk)
- at_exit  in  1  player overlaps level exit door (level)
- screen  out  3  screen_t: START, PLAY, PAUSE, RESPAWN, OVER, WIN
- game_run  out  1  movement FSM enable; high only in PLAY
- player_rst  out  1  one-clk pulse: return player to spawn
- level  out  3  current level, 0..LEVEL_MAX
- lives  out  2  remaining lives
- time_sec  out  10  elapsed play seconds, saturating

Behaviour:
- Reset values: state START, screen START, game_run 0, player_rst 0, level 0, lives LIVES_INIT, time_sec 0, frame and respawn counters 0, edge-detect registers 0.
- Edge detection: enter_p, space_p and frame_tick are rising edges of key_enter, key_space and vsync. Each uses one register stage and lasts exactly 1 clk. A key held through reset produces no edge.
- Registered outputs: all outputs are registered. A state change is visible on outputs 1 clk after the triggering input cycle.
- State START: on enter_p → PLAY.
  - In the same transition: level=0, lives=LIVES_INIT, time_sec=0, frame counter=0, player_rst pulse.
- State PLAY: game_run=1. Evaluate in this priority order:
  1. hit_hazard: lives decrements. If lives was 1 → OVER (lives becomes 0). Otherwise → RESPAWN with player_rst pulse.
  2. at_exit: if level==LEVEL_MAX → WIN. Otherwise level+1, player_rst pulse, stay in PLAY.
  3. space_p → PAUSE.
  - Time base: each frame_tick increments the frame counter. At FRAMES_PER_SEC-1 the counter wraps to 0 and time_sec increments, saturating at TIME_MAX.
- State PAUSE: game_run=0; frame counter and time frozen. space_p → PLAY. enter_p → START (abandon game).
- State RESPAWN: game_run=0; hazard and exit inputs ignored.
  - Counts frame_ticks. After RESPAWN_FRAMES ticks → PLAY; the counter clears on entry.
  - Elapsed time keeps running.
- States OVER, WIN: game_run=0; level, lives and time_sec hold their final values. enter_p → START.
- Simultaneous events in PLAY:
  - hazard plus exit in the same clk: hazard wins.
  - space_p plus hazard: hazard wins and the pause is dropped.
- at_exit held high across a level change: the level advances once per rising edge of at_exit, not per clk. Use a registered edge on at_exit that is gated by PLAY.
- frame_tick coinciding with a state change: the tick is applied to the counters of the state the FSM is leaving.
- rst asserted mid-game: everything returns to reset values on the next clk. No player_rst pulse is issued.
- Arithmetic: lives never underflows below 0. The level counter cannot exceed LEVEL_MAX.

Decomposition:
- Shared package game_pkg: screen_t enum (3-bit, START=0 … WIN=5), LIVES_INIT/LEVEL_MAX defaults and widths.
- draw_screens and the HUD import screen_t from game_pkg.
- Sub-module: edge_det (1-bit rising-edge detector, clk/rst/in/pulse). Instantiated for enter, space, vsync and at_exit.
- The FSM and counters stay in game_ctrl.

Test Plan:
- Reset with key_enter held high, then release and re-press → START held until the press; the press gives screen=PLAY, lives=3, level=0, one player_rst pulse.
- In PLAY, 120 vsync pulses → time_sec=2. Then space_p and 120 more vsyncs → PAUSE with time_sec still 2. Then space_p → PLAY.
- Three hit_hazard events, each after RESPAWN completes → lives 2 then 1 with RESPAWN lasting exactly 90 frames each time. The third hit gives OVER with lives=0. Then enter_p → START.
- at_exit held high for 10 clks at level 0 → level=1 exactly once with one player_rst pulse. Repeat up to level 4, then at_exit → WIN.
- hit_hazard and at_exit asserted in the same clk with lives=2 → RESPAWN, lives=1, level unchanged.
- Force time_sec to 999 in PLAY, then 60 more frames → time_sec stays 999. rst mid-PLAY → all outputs at reset values the next clk.
